// File: rtl/encout_pkg.sv
// encout_pkg: shared FSM states and ENCOUT register map for the APB requester
package encout_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam logic [31:0] ENCOUT_CTL = 32'hA011_C100;
  localparam logic [31:0] ENCOUT_VER = 32'hA011_2300;
endpackage

// File: rtl/encout_apb_master.sv
// encout_apb_master: single-command APB3 requester with wait-state timeout and held response
module encout_apb_master
  import encout_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_pclk,
  input  logic        i_preset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_rsp_timeout,
  output logic [31:0] o_paddr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  input  logic        i_pready,
  input  logic [31:0] i_prdata,
  input  logic        i_pslverr
);
  localparam logic [7:0] TO = 8'(TIMEOUT_CYC);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic cmd_ready_q, cmd_ready_d, psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_ready_d = cmd_ready_q;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && cmd_ready_q) begin
          state_d = SETUP;
          cmd_ready_d = 1'b0;
          psel_d = 1'b1;
          pwrite_d = i_cmd_write;
          paddr_d = i_cmd_addr;
          pwdata_d = i_cmd_wdata;
          cnt_d = 8'd0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        cnt_d = i_pready ? cnt_q : cnt_q + 8'd1;
        if (i_pready || cnt_d == TO) begin
          state_d = RESP;
          psel_d = 1'b0;
          penable_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (i_pready && !pwrite_q) ? i_prdata : 32'd0;
          rsp_err_d = i_pready ? i_pslverr : 1'b1;
          rsp_timeout_d = !i_pready;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      cmd_ready_q <= 1'b0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= 32'd0;
      pwdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign o_cmd_ready = cmd_ready_q;
  assign o_psel = psel_q;
  assign o_penable = penable_q;
  assign o_pwrite = pwrite_q;
  assign o_paddr = paddr_q;
  assign o_pwdata = pwdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err = rsp_err_q;
  assign o_rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_encout_apb_master.sv
// tb_encout_apb_master: directed and randomized transactions checked against a transaction-level model
module tb_encout_apb_master;
  import encout_pkg::*;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, prdata = '0;
  logic pready = 1'b0, pslverr = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  encout_apb_master #(.TIMEOUT_CYC(TO)) dut (
    .i_pclk(clk), .i_preset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_paddr(paddr), .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_pwdata(pwdata),
    .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic chk_apb(input string tag, input logic s, input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_psel"}, 32'(psel), 32'(s));
    chk({tag, "_penable"}, 32'(penable), 32'(e));
    chk({tag, "_pwrite"}, 32'(pwrite), 32'(w));
    chk({tag, "_paddr"}, paddr, a);
    chk({tag, "_pwdata"}, pwdata, d);
  endtask
  task automatic chk_rsp(input string tag, input logic [31:0] rd, input logic er, input logic tmo);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(er));
    chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(tmo));
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
  endtask
  // w: low-pready cycles before pready rises; d: cycles rsp_ready is held low
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int w,
                        input logic [31:0] rd, input logic se, input int d);
    int n_acc;
    logic tmo;
    logic [31:0] exp_rd;
    for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    tmo = (w >= TO);
    n_acc = tmo ? TO : w + 1;
    exp_rd = (wr || tmo) ? 32'd0 : rd;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    chk_apb("setup", 1'b1, 1'b0, wr, a, wd);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      chk_apb("access", 1'b1, 1'b1, wr, a, wd);
      pready = (k == w);
      prdata = pready ? rd : $urandom;
      pslverr = pready ? se : 1'($urandom);
    end
    @(negedge clk);
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    chk_rsp("rsp", exp_rd, tmo | (se & ~tmo), tmo);
    for (int i = 0; i < d; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk_rsp("rsp_hold", exp_rd, tmo | (se & ~tmo), tmo);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("rsp_done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rsp_done_psel", 32'(psel), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
    chk_apb("rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    do_txn(1'b1, ENCOUT_CTL, 32'h0000_0001, 0, 32'hDEAD_BEEF, 1'b0, 0);
    do_txn(1'b0, ENCOUT_VER, 32'hCAFE_0000, 3, 32'h1234_5678, 1'b0, 0);
    do_txn(1'b0, ENCOUT_VER, 32'h0, 1, 32'hA5A5_0F0F, 1'b1, 1);
    do_txn(1'b0, ENCOUT_CTL, 32'h0, TO, 32'h1111_2222, 1'b0, 0);
    do_txn(1'b1, ENCOUT_CTL, 32'h5555_AAAA, TO - 1, 32'h3333_4444, 1'b0, 0);
    do_txn(1'b0, ENCOUT_VER, 32'h0, TO - 1, 32'h7777_8888, 1'b0, 0);
    do_txn(1'b1, ENCOUT_CTL, 32'h0BAD_F00D, 40, 32'h0, 1'b0, 2);
    do_txn(1'b0, ENCOUT_VER, 32'h0, 2, 32'h9ABC_DEF0, 1'b0, 5);
    for (int i = 0; i < 3 && !cmd_ready; i++) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ENCOUT_VER;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_txn(1'b0, ENCOUT_CTL, 32'h0, 0, 32'h0F0F_1234, 1'b0, 0);
    for (int t = 0; t < 25; t++)
      do_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, TO + 3)), $urandom,
             1'($urandom), int'($urandom_range(0, 3)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
